// File: rtl/toggle_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
package toggle_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_PRESS_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets both stages to 0 asynchronously.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/toggle_debouncer.sv
// Synchronises and debounces a raw pushbutton.
// Emits one t/en strobe per accepted press, plus the debounced level and a press counter.
module toggle_debouncer
  import toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PRESS_W         = DEFAULT_PRESS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  output logic               t,
  output logic               en,
  output logic               level,
  output logic [PRESS_W-1:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               btn_s;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               t_q, t_d;
  logic               level_q, level_d;
  logic [PRESS_W-1:0] press_q, press_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (btn_in),
    .q_o (btn_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    press_d = press_q;
    case (state_q)
      S_LOW: begin
        if (btn_s) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (!btn_s) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          // Press accepted: strobe and count land in the same registered cycle.
          state_d = S_HIGH;
          t_d     = 1'b1;
          press_d = press_q + PRESS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!btn_s) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (btn_s) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == S_HIGH) || (state_d == S_FALL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      level_q <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign t           = t_q;
  assign en          = t_q;
  assign level       = level_q;
  assign press_count = press_q;

endmodule

// File: doc/toggle_debouncer.md
Name: toggle_debouncer

Overview:
Upstream conditioning stage for the toggle latch. It takes a raw, bouncing, asynchronous pushbutton and synchronises and debounces it. Each confirmed press produces exactly one single-cycle t/en strobe, so the downstream latch toggles once per physical press. It also exposes the debounced level and a wrapping press counter for observation.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change; legal range >= 1
PRESS_W, 8, width of press_count

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
btn_in  input  1  raw pushbutton, asynchronous to clk, may bounce
t  output  1  toggle strobe to the latch, one cycle per accepted press
en  output  1  enable strobe to the latch, identical to t
level  output  1  debounced button level
press_count  output  PRESS_W  number of accepted presses, wraps modulo 2^PRESS_W

Behaviour:
- Interface (already decided): one clock, clk. reset is asynchronous and active-high. All registers clear immediately on reset assertion, independent of clk.
- Reset values:
  - t=0, en=0, level=0, press_count=0.
  - Synchroniser flops = 0.
  - State = S_LOW, debounce counter = 0.
- Synchroniser: two flops, btn_in -> s1 -> btn_s. The FSM sees only btn_s.
- Debounce counter: width clog2(DEBOUNCE_CYCLES)+1. It is cleared on every entry to S_RISE or S_FALL.
- FSM states and transitions:
  - S_LOW: btn_s=1 -> S_RISE, cnt=0. Otherwise stay.
  - S_RISE:
    - btn_s=0 -> S_LOW (bounce rejected, no output change).
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, register t=en=1 for the next cycle.
    - Otherwise cnt++.
  - S_HIGH: btn_s=0 -> S_FALL, cnt=0. Otherwise stay.
  - S_FALL:
    - btn_s=1 -> S_HIGH (bounce rejected).
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW.
    - Otherwise cnt++.
    - No strobe on release.
- Outputs:
  - t and en are registered and high for exactly one cycle per S_RISE->S_HIGH transition. They are never high on consecutive cycles.
  - level is registered: 1 in S_HIGH and S_FALL, 0 in S_LOW and S_RISE.
  - press_count increments by 1, in the same cycle t is registered high, and wraps from 2^PRESS_W-1 to 0.
- Latency: let edge k be the first clk edge sampling btn_in=1 with btn_in stable afterwards. Then t, en, level and the new press_count are all visible in the cycle following edge k+DEBOUNCE_CYCLES+2. The release path has the same latency to level=0.
- DEBOUNCE_CYCLES=1: the first S_RISE cycle with btn_s=1 accepts.
- Button held indefinitely: exactly one strobe; no auto-repeat.
- Reset mid-operation: any pending press or release is discarded.
  - If btn_in is held through reset deassertion, it counts as a new press.
  - t fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- btn_in glitches shorter than one clk period may be missed entirely. This is acceptable.

Decomposition:
- Package toggle_pkg:
  - state enum {S_LOW, S_RISE, S_HIGH, S_FALL}, 2-bit encoding.
  - DEFAULT_DEBOUNCE_CYCLES=4.
  - DEFAULT_PRESS_W=8.
- One natural sub-module, sync_2ff (two-flop synchroniser with async active-high reset to 0). It is reused for any other asynchronous inputs.

Test Plan:
1. Reset: assert reset with btn_in=1 mid-count -> t=0, en=0, level=0, press_count=0 immediately, before any clk edge.
2. Clean press, DEBOUNCE_CYCLES=4: btn_in 0->1 before edge k, held 20 cycles.
   - t=en=1 only in the cycle after edge k+6.
   - level=1 from that cycle onward.
   - press_count=1.
3. Press bounce: btn_in toggles high 3 cycles / low 1 cycle, repeated 5 times -> t never asserts, level=0, press_count=0.
4. Release bounce: from level=1, btn_in low 2 cycles, high 1, then low steady.
   - level stays 1 through the bounce.
   - level goes 0 in the cycle after edge j+6, where edge j is the first edge of steady low.
   - No strobe on release.
5. Wrap, PRESS_W=2: five clean presses -> press_count sequence 1,2,3,0,1; exactly five single-cycle t pulses.
6. Reset mid-S_RISE: btn_in held, reset pulsed when cnt=2, btn_in still held.
   - No strobe during or immediately after reset.
   - t fires in the cycle after edge k+6, where edge k is the first post-reset edge.
   - press_count=1.
